// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and width limits.
package serial_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_subtract.sv
// Single-bit full subtractor: diff = a - b - borrowin, borrowOut set when the bit underflows.
module full_subtract (
  input  logic a,
  input  logic b,
  input  logic borrowin,
  output logic diff,
  output logic borrowOut
);

  assign diff      = a ^ b ^ borrowin;
  assign borrowOut = (~a & b) | (~(a ^ b) & borrowin);

endmodule

// File: rtl/serial_subtract.sv
// Bit-serial unsigned subtractor: one bit of a - b per clock, LSB first, around one full_subtract.
module serial_subtract
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_subtract: WIDTH out of range");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow_reg;
  logic [CW-1:0]    count_reg;

  logic             fs_diff;
  logic             fs_borrow;
  logic [WIDTH-1:0] diff_next;
  logic             last_bit;

  full_subtract u_fs (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .borrowin  (borrow_reg),
    .diff      (fs_diff),
    .borrowOut (fs_borrow)
  );

  // New diff bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_next = fs_diff;
    end else begin : g_wn
      assign diff_next = {fs_diff, diff_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      borrow_reg <= 1'b0;
      count_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr       <= a;
            b_sr       <= b;
            diff_sr    <= '0;
            borrow_reg <= 1'b0;
            count_reg  <= '0;
            busy       <= 1'b1;
            state_reg  <= S_RUN;
          end else begin
            state_reg  <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr       <= a_sr >> 1;
          b_sr       <= b_sr >> 1;
          diff_sr    <= diff_next;
          borrow_reg <= fs_borrow;
          if (last_bit) begin
            // Outputs are only refreshed here, so they hold steady through RUN.
            count_reg  <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= diff_next;
            borrow_out <= fs_borrow;
            state_reg  <= S_DONE;
          end else begin
            count_reg  <= count_reg + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
